transfer_reg_1: RTL



---
 rtl/transfer_reg_1.sv | 111 +++++++++++
 1 files changed

// File: rtl/transfer_reg_1.sv
// transfer_reg_1: lower half of the transfer register (TR1-TR9) plus the TR9D
// delay latch feeding the upper stage. Parallel load from buffer A/B at X2,
// clear at X2+CLTR, serial shift at Z8+SRTR with a saturating 9-shift count.
// Optional feature: define TR_PARITY_EN to add the registered odd-parity output TRLPAR.

module transfer_reg_1 (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       V1,
    input  logic       W1,
    input  logic       X2,
    input  logic       Y6,
    input  logic       Z8,
    input  logic       V4MOD2,
    input  logic       CLTR,
    input  logic       TBR,
    input  logic       SRTR,
    input  logic       MAOV,
    input  logic       MBOV,
    input  logic [8:0] BRA,
    input  logic [8:0] BRB,
    input  logic       SIN,
    output logic [8:0] TR,
    output logic       TR1V,
    output logic       TR1N,
    output logic       TR9D,
    output logic       TR9DN,
    output logic       SHF9
`ifdef TR_PARITY_EN
    ,
    output logic       TRLPAR
`endif
);

    logic [8:0] tr_q, tr_d;
    logic       tr9d_q, tr9d_d;
    logic [3:0] shcnt_q, shcnt_d;
    logic       shf9_q, shf9_d;

    // These phases only ever hold state; they are kept on the port list for the
    // timing generator's one-hot bus.
    logic unused_strobes;
    assign unused_strobes = ^{V1, W1, Y6, V4MOD2};

    // Next-state: X2 actions win over a coincident Z8 shift.
    always_comb begin
        tr_d    = tr_q;
        tr9d_d  = tr9d_q;
        shcnt_d = shcnt_q;
        shf9_d  = shf9_q;
        if (X2) begin
            if (CLTR) begin
                tr_d    = '0;
                tr9d_d  = 1'b0;
                shcnt_d = '0;
                shf9_d  = 1'b0;
            end else if (TBR && MAOV) begin
                tr_d    = BRA;
                shcnt_d = '0;
                shf9_d  = 1'b0;
            end else if (TBR && MBOV) begin
                tr_d    = BRB;
                shcnt_d = '0;
                shf9_d  = 1'b0;
            end
        end else if (Z8 && SRTR) begin
            tr9d_d  = tr_q[8];
            tr_d    = {tr_q[7:0], SIN};
            shcnt_d = (shcnt_q == 4'd9) ? 4'd9 : shcnt_q + 4'd1;
            shf9_d  = (shcnt_d == 4'd9);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            tr_q    <= '0;
            tr9d_q  <= 1'b0;
            shcnt_q <= '0;
            shf9_q  <= 1'b0;
        end else begin
            tr_q    <= tr_d;
            tr9d_q  <= tr9d_d;
            shcnt_q <= shcnt_d;
            shf9_q  <= shf9_d;
        end
    end

    assign TR    = tr_q;
    assign TR1V  = tr_q[0];
    assign TR1N  = ~tr_q[0];
    assign TR9D  = tr9d_q;
    assign TR9DN = ~tr9d_q;
    assign SHF9  = shf9_q;

`ifdef TR_PARITY_EN
    logic trlpar_q;

    // Parity trails TR by one cycle; set makes the 10-bit total odd.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            trlpar_q <= 1'b1;
        end else begin
            trlpar_q <= ~^tr_q;
        end
    end

    assign TRLPAR = trlpar_q;
`endif

endmodule
